// File: rtl/sram_word_controller_pkg.sv
// Shared definitions for the 32-bit to 16-bit SRAM word bridge: FSM encoding,
// default base address and the byte-address to half-word-address mapping.
package sram_word_controller_pkg;

    localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_LO_W = 3'd2,
        ST_HI   = 3'd3,
        ST_HI_W = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Only 17 word-index bits reach the SRAM, so out-of-range addresses wrap.
    function automatic logic [17:0] sram_half_addr(input logic [31:0] addr,
                                                   input logic [31:0] base,
                                                   input logic        hi_half);
        return {17'((addr - base) >> 2), hi_half};
    endfunction

endpackage

// File: rtl/sram_word_controller.sv
// Splits 32-bit word accesses into two 16-bit SRAM cycles, low half first.
// Latency 5 cycles from request to ready; ready stays low (pipeline frozen) while busy.
module sram_word_controller
    import sram_word_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = SRAM_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrEn,
    input  logic        rdEn,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    state_t      state_q, state_d;
    logic        op_wr_q, op_wr_d;
    logic [31:0] rdata_q, rdata_d;

    logic in_access;
    logic hi_phase;
    logic wr_access;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_wr_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_wr_d = op_wr_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (rdEn || wrEn) begin
                    state_d = ST_LO;
                    op_wr_d = wrEn;
                end
            end
            ST_LO:   state_d = ST_LO_W;
            ST_LO_W: begin
                state_d = ST_HI;
                if (!op_wr_q) rdata_d[15:0] = SRAM_DQ;
            end
            ST_HI:   state_d = ST_HI_W;
            ST_HI_W: begin
                state_d = ST_DONE;
                if (!op_wr_q) rdata_d[31:16] = SRAM_DQ;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_access = (state_q == ST_LO) || (state_q == ST_LO_W) ||
                       (state_q == ST_HI) || (state_q == ST_HI_W);
    assign hi_phase  = (state_q == ST_HI) || (state_q == ST_HI_W);
    assign wr_access = op_wr_q && in_access;

    // The op bit is stale outside LO..HI_W, so every SRAM control is gated by in_access.
    assign SRAM_WE_N = !(op_wr_q && ((state_q == ST_LO) || (state_q == ST_HI)));
    assign SRAM_OE_N = wr_access;
    assign SRAM_DQ   = wr_access ? (hi_phase ? writeData[31:16] : writeData[15:0]) : 16'hzzzz;
    assign SRAM_ADDR = sram_half_addr(address, BASE_ADDR, hi_phase);
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;

    assign ready    = ((state_q == ST_IDLE) && !(rdEn || wrEn)) || (state_q == ST_DONE);
    assign readData = rdata_q;

endmodule

// File: tb/tb_sram_word_controller.sv
// Bench for sram_word_controller with a behavioural 256K x 16 SRAM on the DQ bus.
module tb_sram_word_controller;

    logic        clk;
    logic        rst;
    logic        wrEn;
    logic        rdEn;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;

    sram_word_controller dut (
        .clk       (clk),
        .rst       (rst),
        .wrEn      (wrEn),
        .rdEn      (rdEn),
        .address   (address),
        .writeData (writeData),
        .readData  (readData),
        .ready     (ready),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_WE_N (SRAM_WE_N),
        .SRAM_UB_N (SRAM_UB_N),
        .SRAM_LB_N (SRAM_LB_N),
        .SRAM_CE_N (SRAM_CE_N),
        .SRAM_OE_N (SRAM_OE_N)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM model; the probe drives a fixed pattern to see whether the DUT releases DQ.
    logic [15:0] mem [0:262143];
    logic        model_en;
    logic        probe_en;
    logic        tb_drv_en;
    logic [15:0] tb_drv_val;

    always_comb begin
        tb_drv_en  = 1'b0;
        tb_drv_val = 16'h0000;
        if (probe_en) begin
            tb_drv_en  = 1'b1;
            tb_drv_val = 16'h1234;
        end else if (model_en && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) begin
            tb_drv_en  = 1'b1;
            tb_drv_val = mem[SRAM_ADDR];
        end
    end
    assign sram_dq = tb_drv_en ? tb_drv_val : 16'hzzzz;

    always @(posedge clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR] <= sram_dq;
    end

    int n_pass;
    int n_total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive the DUT bus and check nobody else is on it besides the probe.
    task automatic chk_dq_released(input string name);
        model_en = 1'b0;
        probe_en = 1'b1;
        #1;
        chk(name, {16'h0, sram_dq}, 32'h0000_1234);
        probe_en = 1'b0;
        model_en = 1'b1;
    endtask

    // Starts at a negedge; returns in the DONE cycle (or after the cycle budget).
    task automatic run_txn(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] wdata, input int drop_at,
                           output int stalls, output logic [17:0] a1,
                           output logic [17:0] a3, output int we_lo);
        wrEn      = wr;
        rdEn      = rd;
        address   = addr;
        writeData = wdata;
        stalls    = 0;
        we_lo     = 0;
        a1        = '0;
        a3        = '0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            if (c == drop_at) begin
                wrEn = 1'b0;
                rdEn = 1'b0;
            end
            #1;
            if (c == 1) a1 = SRAM_ADDR;
            if (c == 3) a3 = SRAM_ADDR;
            if (!SRAM_WE_N) we_lo++;
            if (ready) break;
            stalls++;
        end
        wrEn = 1'b0;
        rdEn = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [17:0] lo;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int          stalls;
        int          we_lo;
        int          highs;
        logic [17:0] a1;
        logic [17:0] a3;

        n_pass  = 0;
        n_total = 0;

        vecs[0]  = '{1'b1, 1'b0, 32'd1024,   32'hDEAD_BEEF, 18'd0,       32'h0000_0000};
        vecs[1]  = '{1'b0, 1'b1, 32'd1024,   32'h0000_0000, 18'd0,       32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b0, 32'd1028,   32'h1234_5678, 18'd2,       32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 1'b1, 32'd1028,   32'h0000_0000, 18'd2,       32'h1234_5678};
        vecs[4]  = '{1'b0, 1'b1, 32'd1024,   32'h0000_0000, 18'd0,       32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 1'b1, 32'd1032,   32'hA5A5_5A5A, 18'd4,       32'hDEAD_BEEF};
        vecs[6]  = '{1'b0, 1'b1, 32'd1032,   32'h0000_0000, 18'd4,       32'hA5A5_5A5A};
        vecs[7]  = '{1'b1, 1'b0, 32'd525312, 32'hCAFE_F00D, 18'd0,       32'hA5A5_5A5A};
        vecs[8]  = '{1'b0, 1'b1, 32'd1024,   32'h0000_0000, 18'd0,       32'hCAFE_F00D};
        vecs[9]  = '{1'b1, 1'b0, 32'd1020,   32'h0BAD_F00D, 18'h3FFFE,   32'hCAFE_F00D};
        vecs[10] = '{1'b0, 1'b1, 32'd1020,   32'h0000_0000, 18'h3FFFE,   32'h0BAD_F00D};

        rst       = 1'b1;
        wrEn      = 1'b0;
        rdEn      = 1'b0;
        address   = 32'd1024;
        writeData = 32'hFFFF_FFFF;
        model_en  = 1'b1;
        probe_en  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_ready",    {31'b0, ready},     32'd1);
        chk("reset_we_n",     {31'b0, SRAM_WE_N}, 32'd1);
        chk("reset_oe_n",     {31'b0, SRAM_OE_N}, 32'd0);
        chk("reset_readdata", readData,           32'h0);
        chk_dq_released("reset_dq_hiz");

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            run_txn(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, 99,
                    stalls, a1, a3, we_lo);
            chk($sformatf("v%0d_stalls", i),   stalls,      32'd5);
            chk($sformatf("v%0d_addr_lo", i),  {14'b0, a1}, {14'b0, vecs[i].lo});
            chk($sformatf("v%0d_addr_hi", i),  {14'b0, a3}, {14'b0, vecs[i].lo + 18'd1});
            chk($sformatf("v%0d_we_pulses", i), we_lo,      vecs[i].wr ? 32'd2 : 32'd0);
            chk($sformatf("v%0d_readdata", i), readData,    vecs[i].exp_rd);
            if (vecs[i].wr) begin
                @(negedge clk);
                chk($sformatf("v%0d_mem_lo", i), {16'b0, mem[vecs[i].lo]},
                    {16'b0, vecs[i].wdata[15:0]});
                chk($sformatf("v%0d_mem_hi", i), {16'b0, mem[vecs[i].lo + 18'd1]},
                    {16'b0, vecs[i].wdata[31:16]});
            end
        end

        // Continuous read request: ready is high once every six cycles.
        @(negedge clk);
        rdEn    = 1'b1;
        address = 32'd1024;
        highs   = 0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (ready) highs++;
        end
        rdEn = 1'b0;
        chk("cont_ready_highs", highs,    32'd2);
        chk("cont_readdata",    readData, 32'hCAFE_F00D);

        // Request withdrawn after LO: the write still runs to completion.
        @(negedge clk);
        run_txn(1'b1, 1'b0, 32'd1036, 32'h1111_2222, 2, stalls, a1, a3, we_lo);
        chk("drop_stalls",   stalls,   32'd5);
        chk("drop_we",       we_lo,    32'd2);
        chk("drop_readdata", readData, 32'hCAFE_F00D);
        @(negedge clk);
        chk("drop_mem_lo", {16'b0, mem[6]}, 32'h0000_2222);
        chk("drop_mem_hi", {16'b0, mem[7]}, 32'h0000_1111);

        // Reset while the high half of a write is in flight.
        @(negedge clk);
        wrEn      = 1'b1;
        address   = 32'd1040;
        writeData = 32'h3333_4444;
        repeat (3) @(negedge clk);
        #1;
        chk("rstmid_we_in_hi", {31'b0, SRAM_WE_N}, 32'd0);
        rst  = 1'b1;
        wrEn = 1'b0;
        @(negedge clk);
        #1;
        chk("rstmid_ready",    {31'b0, ready},     32'd1);
        chk("rstmid_we_n",     {31'b0, SRAM_WE_N}, 32'd1);
        chk("rstmid_readdata", readData,           32'h0);
        chk("rstmid_mem_lo",   {16'b0, mem[8]},    32'h0000_4444);
        chk_dq_released("rstmid_dq_hiz");
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_ready", {31'b0, ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
